// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache, one 32-bit word per line.
// A miss issues a single word read downstream; a flush cancels the pending response but the fill still completes.
module icache_direct_mapped #(
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_from_fetcher,
  input  logic                  valid_from_fetcher,
  output logic                  rdy_to_fetcher,
  output logic [DATA_WIDTH-1:0] data_to_fetcher,
  input  logic                  flush_from_rob,
  output logic [ADDR_WIDTH-1:0] addr_to_mem,
  output logic                  valid_to_mem,
  input  logic                  rdy_from_mem,
  input  logic [DATA_WIDTH-1:0] data_from_mem
);
  localparam int TW    = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES = 1 << INDEX_WIDTH;
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_DATA} state_t;
  state_t                  r_state, w_next;
  logic [LINES-1:0]        r_valid;
  logic [TW-1:0]           r_tag  [LINES];
  logic [DATA_WIDTH-1:0]   r_word [LINES];
  logic [INDEX_WIDTH-1:0]  r_pidx;
  logic [TW-1:0]           r_ptag;
  logic                    r_cancel, r_rdy, r_vmem;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_maddr;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [TW-1:0]           w_tag;
  logic                    w_hit, w_accept, w_fill, w_respond, w_unused;
  assign w_idx     = addr_from_fetcher[INDEX_WIDTH+1:2];
  assign w_tag     = addr_from_fetcher[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // the cycle carrying a response pulse ignores the still-held old request
  assign w_accept  = (r_state == IDLE) && valid_from_fetcher && !flush_from_rob && !r_rdy;
  assign w_fill    = (r_state == MEM_DATA);
  assign w_respond = w_fill && !r_cancel && !flush_from_rob;
  assign w_unused  = ^addr_from_fetcher[1:0];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_accept && !w_hit) ? MEM_REQ : IDLE;
      MEM_REQ: w_next = rdy_from_mem ? MEM_DATA : MEM_REQ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= '0;
      r_cancel <= 1'b0;
      r_rdy    <= 1'b0;
      r_data   <= '0;
      r_vmem   <= 1'b0;
      r_maddr  <= '0;
      r_pidx   <= '0;
      r_ptag   <= '0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_accept && w_hit) || w_respond;
      if (w_accept && w_hit)
        r_data <= r_word[w_idx];
      else if (w_respond)
        r_data <= data_from_mem;
      if (w_accept && !w_hit) begin
        r_pidx  <= w_idx;
        r_ptag  <= w_tag;
        r_maddr <= {addr_from_fetcher[ADDR_WIDTH-1:2], 2'b00};
        r_vmem  <= 1'b1;
      end else if (r_state == MEM_REQ && rdy_from_mem)
        r_vmem <= 1'b0;
      if (w_fill)
        r_cancel <= 1'b0;
      else if (r_state != IDLE && flush_from_rob)
        r_cancel <= 1'b1;
      if (w_fill)
        r_valid[r_pidx] <= 1'b1;
    end
  end
  // tag and word arrays need no reset: the valid bits qualify them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_pidx]  <= r_ptag;
      r_word[r_pidx] <= data_from_mem;
    end
  end
  assign rdy_to_fetcher  = r_rdy;
  assign data_to_fetcher = r_data;
  assign valid_to_mem    = r_vmem;
  assign addr_to_mem     = r_maddr;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: table-driven, hand-written and random fetch transactions checked against a line-array model.
module tb_icache_direct_mapped;
  logic        clk = 0;
  logic        rst;
  logic [31:0] addr_from_fetcher;
  logic        valid_from_fetcher;
  logic        rdy_to_fetcher;
  logic [31:0] data_to_fetcher;
  logic        flush_from_rob;
  logic [31:0] addr_to_mem;
  logic        valid_to_mem;
  logic        rdy_from_mem;
  logic [31:0] data_from_mem;
  int errors = 0;
  int checks = 0;
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          fl;
    bit          pre_fl;
    bit          hit;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [12];
  icache_direct_mapped dut (
    .clk(clk), .rst(rst),
    .addr_from_fetcher(addr_from_fetcher), .valid_from_fetcher(valid_from_fetcher),
    .rdy_to_fetcher(rdy_to_fetcher), .data_to_fetcher(data_to_fetcher),
    .flush_from_rob(flush_from_rob),
    .addr_to_mem(addr_to_mem), .valid_to_mem(valid_to_mem),
    .rdy_from_mem(rdy_from_mem), .data_from_mem(data_from_mem)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h100) ? 32'h0010_0093 : ((w * 32'h9E37_79B1) ^ 32'hA5A5_0000);
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input logic [31:0] a, input int lat, input int fl, input bit pre_fl,
                          input bit exp_hit, input logic [31:0] exp_data);
    logic [5:0] idx;
    idx = a[7:2];
    addr_from_fetcher = a;
    valid_from_fetcher = 1;
    if (pre_fl) begin
      flush_from_rob = 1;
      step();
      chk("idle_flush_rdy", 32'(rdy_to_fetcher), 0);
      chk("idle_flush_vmem", 32'(valid_to_mem), 0);
      flush_from_rob = 0;
    end
    step();
    if (exp_hit) begin
      chk("hit_rdy", 32'(rdy_to_fetcher), 1);
      chk("hit_data", data_to_fetcher, exp_data);
      chk("hit_vmem", 32'(valid_to_mem), 0);
    end else begin
      chk("miss_rdy", 32'(rdy_to_fetcher), 0);
      chk("miss_vmem", 32'(valid_to_mem), 1);
      chk("miss_addr", addr_to_mem, {a[31:2], 2'b00});
      for (int k = 0; k <= lat; k++) begin
        if (k == fl) begin
          flush_from_rob = 1;
          valid_from_fetcher = 0;
        end
        rdy_from_mem = (k == lat);
        step();
        flush_from_rob = 0;
        chk("req_vmem", 32'(valid_to_mem), (k < lat) ? 1 : 0);
        if (k < lat) chk("req_addr", addr_to_mem, {a[31:2], 2'b00});
        chk("req_rdy", 32'(rdy_to_fetcher), 0);
      end
      rdy_from_mem = 0;
      data_from_mem = mem_word(a);
      step();
      data_from_mem = $urandom;
      if (fl >= 0)
        chk("cancel_rdy", 32'(rdy_to_fetcher), 0);
      else begin
        chk("fill_rdy", 32'(rdy_to_fetcher), 1);
        chk("fill_data", data_to_fetcher, exp_data);
      end
      m_valid[idx] = 1;
      m_tag[idx] = a[31:8];
      m_data[idx] = mem_word(a);
    end
    valid_from_fetcher = 0;
    step();
    chk("post_rdy", 32'(rdy_to_fetcher), 0);
  endtask
  initial begin
    logic [31:0] a, d;
    int lat, fl;
    bit h;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    tbl[0]  = '{32'h100, 2, -1, 0, 0, 32'h0010_0093};
    tbl[1]  = '{32'h100, 0, -1, 0, 1, 32'h0010_0093};
    tbl[2]  = '{32'h103, 0, -1, 0, 1, 32'h0010_0093};
    tbl[3]  = '{32'h200, 1, -1, 0, 0, mem_word(32'h200)};
    tbl[4]  = '{32'h201, 0, -1, 0, 1, mem_word(32'h200)};
    tbl[5]  = '{32'h100, 0, -1, 0, 0, 32'h0010_0093};
    tbl[6]  = '{32'h300, 3, 1, 0, 0, mem_word(32'h300)};
    tbl[7]  = '{32'h300, 0, -1, 0, 1, mem_word(32'h300)};
    tbl[8]  = '{32'h004, 0, -1, 0, 0, mem_word(32'h004)};
    tbl[9]  = '{32'h104, 4, -1, 1, 0, mem_word(32'h104)};
    tbl[10] = '{32'h006, 0, -1, 0, 0, mem_word(32'h004)};
    tbl[11] = '{32'h302, 0, -1, 1, 1, mem_word(32'h300)};
    rst = 1;
    addr_from_fetcher = 0;
    valid_from_fetcher = 0;
    flush_from_rob = 0;
    rdy_from_mem = 0;
    data_from_mem = 0;
    step();
    step();
    chk("rst_rdy", 32'(rdy_to_fetcher), 0);
    chk("rst_data", data_to_fetcher, 0);
    chk("rst_vmem", 32'(valid_to_mem), 0);
    chk("rst_maddr", addr_to_mem, 0);
    rst = 0;
    step();
    for (int i = 0; i < 12; i++)
      do_fetch(tbl[i].addr, tbl[i].lat, tbl[i].fl, tbl[i].pre_fl, tbl[i].hit, tbl[i].data);
    addr_from_fetcher = 32'h300;
    valid_from_fetcher = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_rdy", 32'(rdy_to_fetcher), (i % 2 == 0) ? 1 : 0);
      chk("held_vmem", 32'(valid_to_mem), 0);
    end
    valid_from_fetcher = 0;
    step();
    addr_from_fetcher = 32'h1C4;
    valid_from_fetcher = 1;
    step();
    chk("rstmd_vmem", 32'(valid_to_mem), 1);
    rdy_from_mem = 1;
    step();
    rdy_from_mem = 0;
    data_from_mem = mem_word(32'h1C4);
    #2 rst = 1;
    #1;
    chk("rstmd_rdy", 32'(rdy_to_fetcher), 0);
    chk("rstmd_data", data_to_fetcher, 0);
    chk("rstmd_vmem0", 32'(valid_to_mem), 0);
    chk("rstmd_maddr", addr_to_mem, 0);
    step();
    chk("rstmd_hold_rdy", 32'(rdy_to_fetcher), 0);
    valid_from_fetcher = 0;
    rst = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    step();
    do_fetch(32'h1C4, 1, -1, 0, 0, mem_word(32'h1C4));
    do_fetch(32'h300, 0, -1, 0, 0, mem_word(32'h300));
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 4);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      h = m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
      d = h ? m_data[a[7:2]] : mem_word(a);
      do_fetch(a, lat, fl, $urandom_range(0, 7) == 0, h, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream) and the memory management unit (downstream).
- Serves 32-bit instruction words to the fetcher, one word per line.
- On a miss it issues a word read to the memory management unit, fills the line and returns the word.
- Accepts a flush from the reorder buffer that cancels any outstanding fetch response.

Parameters:
INDEX_WIDTH, 6, log2 of line count (64 lines); index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2]
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, instruction word width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
addr_from_fetcher  in  32  fetch address (byte address, low 2 bits ignored)
valid_from_fetcher  in  1  fetch request, held with stable address until rdy_to_fetcher seen
rdy_to_fetcher  out  1  one-cycle pulse: data_to_fetcher valid this cycle
data_to_fetcher  out  32  instruction word
flush_from_rob  in  1  cancel outstanding fetch (mispredict)
addr_to_mem  out  32  word-aligned miss address {addr[31:2],2'b00}
valid_to_mem  out  1  miss read request to memory management unit
rdy_from_mem  in  1  memory unit: word is on data_from_mem in the next cycle
data_from_mem  in  32  little-endian word from memory unit

Behaviour:
- Reset (async, immediate): all line valid bits cleared, state IDLE, cancelled flag 0.
- Output reset values: rdy_to_fetcher=0, data_to_fetcher=0, valid_to_mem=0, addr_to_mem=0.
- Storage per line: valid bit, tag, 32-bit word.
- States: IDLE, MEM_REQ, MEM_DATA.
- IDLE, request accepted when valid_from_fetcher=1, flush_from_rob=0 and rdy_to_fetcher=0. The cycle carrying a response pulse ignores the still-held old request, so hit throughput is 1 word per 2 cycles.
- Hit (line valid and tag equal):
  - At the next edge: rdy_to_fetcher=1, data_to_fetcher=line word.
  - Stay IDLE. Hit latency is 1 cycle.
- Miss:
  - At the next edge: latch index and tag into pending registers; addr_to_mem={addr[31:2],2'b00}; valid_to_mem=1; go to MEM_REQ.
- MEM_REQ:
  - Hold valid_to_mem and addr_to_mem stable until rdy_from_mem=1 is sampled.
  - At that edge: valid_to_mem=0, go to MEM_DATA.
- MEM_DATA:
  - Write data_from_mem, the pending tag and valid=1 into the pending line; this evicts any old contents.
  - If cancelled=0: at the same edge rdy_to_fetcher=1 and data_to_fetcher=data_from_mem.
  - Clear cancelled and return to IDLE.
  - Miss latency = memory latency + 2 cycles from request to response.
- rdy_to_fetcher is always deasserted the cycle after the pulse. data_to_fetcher holds its last value.
- Flush:
  - IDLE: the request in the same cycle is not accepted and no response is produced.
  - MEM_REQ/MEM_DATA: set cancelled. The memory transaction is never aborted: the fill still completes, but no rdy_to_fetcher is produced.
  - A flush coincident with an already-high rdy_to_fetcher does not retract the pulse; the fetcher discards it.
- A new request arriving while in MEM_REQ/MEM_DATA is not accepted until IDLE.
- Addresses differing only in bits [1:0] map to the same word.
- Reset during MEM_REQ/MEM_DATA returns to IDLE with all lines invalid. The in-flight memory response is ignored.

Test Plan:
- Cold miss: reset, fetch 0x0000_0100. Required: valid_to_mem=1 with addr_to_mem=0x100 one cycle later, held until rdy_from_mem. Memory returns 0x0010_0093 → rdy_to_fetcher pulse with that word 2 cycles after rdy_from_mem.
- Hit: refetch 0x100 → rdy_to_fetcher=1 with 0x0010_0093 one cycle after the request; valid_to_mem stays 0.
- Conflict eviction: fill 0x100, then fetch 0x200 (same index, INDEX_WIDTH=6) → miss, then fill. Refetch 0x100 → miss again.
- Flush mid-miss: fetch 0x300 (miss), assert flush_from_rob while in MEM_REQ. Required: no rdy_to_fetcher pulse. A later fetch of 0x300 hits in 1 cycle.
- Held request: keep valid_from_fetcher high on a hit address for 4 cycles → rdy_to_fetcher pulses in cycles 2 and 4 only, never back-to-back.
- Async reset during MEM_DATA: outputs go to 0 immediately. A subsequent fetch of the just-filled address misses.
